mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
MEM-stage controller of the 16-bit pipeline CPU. It is the consuming end of the EX/MEM pipeline register.
- Decodes the registered memRead/memWrite/ALUResult/data fields.
- Runs multi-cycle accesses on the external SRAM and a handshake UART.
- Stalls the pipeline while an access is in flight.
- Registers the result and pass-through control into the MEM/WB fields.

Parameters:
WAIT_CYCLES, 2, SRAM strobe width in cycles (>=1).
UART_DATA_ADDR, 16'hBF00, address decoded for UART data when mem code is 2'b10 (informational, code selects target).

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
memReadIn  in  2  00 none, 01 RAM, 10 UART data, 11 UART status
memWriteIn  in  2  00 none, 01 RAM, 10 UART data, 11 no-op
ALUResultIn  in  16  address / ALU result
dataIn  in  16  store data
memtoRegIn, regWriteIn  in  1 each  pass-through control
writeSpecRegIn  in  2  pass-through
registerToWriteIdIn  in  3  destination register
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
ram_addr  out  16  SRAM address (registered)
ram_data_o  out  16  SRAM write data (registered)
ram_data_i  in  16  SRAM read data
ram_data_oe  out  1  drive ram_data_o onto bus
ram_en_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low
uart_tx_data  out  16  low byte transmitted
uart_tx_valid  out  1  transmit request
uart_tx_ready  in  1  transmitter accepts
uart_rx_data  in  8  received byte
uart_rx_valid  in  1  byte available
uart_rx_ack  out  1  pop received byte (combinational)
ALUResultOut, memDataOut  out  16 each  to MEM/WB
memtoRegOut, regWriteOut  out  1 each
writeSpecRegOut  out  2
registerToWriteIdOut  out  3

Behaviour:
- Reset (async, RST=0): state IDLE; all outputs 0, except ram_en_n/ram_oe_n/ram_we_n=1. Strobes drop immediately, mid-access included. No completion is written.
- States: IDLE, RAM_RD, RAM_WR, UART_TX, DONE.
- IDLE, no memory op (both codes 00 or write 11): no stall; MEM/WB outputs load the inputs at the next edge; memDataOut=0.
- IDLE, read 10: zero-wait. memDataOut<={8'h00,uart_rx_data} if uart_rx_valid, else 16'h0000. uart_rx_ack=uart_rx_valid in that cycle. No stall.
- IDLE, read 11: zero-wait. memDataOut<={14'b0,uart_rx_valid,uart_tx_ready}. No stall.
- IDLE, read 01 / write 01 / write 10:
  - stall=1 combinationally.
  - Latch address, data and control.
  - MEM/WB regWriteOut and writeSpecRegOut load 0 (bubble).
  - Next state RAM_RD / RAM_WR / UART_TX.
- Read and write both non-zero: the read is performed and the write is ignored.
- RAM_RD: ram_en_n=0, ram_oe_n=0 for exactly WAIT_CYCLES cycles; ram_data_i sampled at the edge ending the last cycle; then DONE.
- RAM_WR: ram_en_n=0, ram_we_n=0 for WAIT_CYCLES cycles; ram_data_oe=1 throughout RAM_WR and in the following DONE cycle (hold); then DONE.
- UART_TX: uart_tx_valid=1 and uart_tx_data stable until uart_tx_ready=1. The transfer completes on the edge where both are high; then DONE. No timeout.
- Stall timing: stall=1 in IDLE-accept and in RAM_RD/RAM_WR/UART_TX.
- DONE:
  - stall=0.
  - Inputs ignored: they still hold the completed instruction.
  - MEM/WB outputs load the latched control and result at the edge; next state IDLE.
- Latency: RAM access stalls for WAIT_CYCLES+1 cycles; the result is visible on outputs the cycle after DONE. UART TX stalls for 1 + cycles until ready.
- Address is not range-checked; no internal RAM byte addressing.

Test Plan:
- ALU op: regWriteIn=1, ALUResultIn=16'h00A5, id=3, codes 00 -> stall never high; next cycle ALUResultOut=16'h00A5, regWriteOut=1, registerToWriteIdOut=3.
- RAM read, WAIT_CYCLES=2: addr 16'h1234, ram_data_i=16'hBEEF -> stall high 3 cycles, ram_oe_n low 2 cycles with ram_addr=16'h1234. Cycle after DONE: memDataOut=16'hBEEF, memtoRegOut=1. Bubble (regWriteOut=0) during the stall.
- RAM write 16'h5A5A @ 16'h0040 -> ram_we_n low 2 cycles, ram_data_oe high 3 cycles, ram_data_o=16'h5A5A, stall high 3 cycles.
- UART TX dataIn=16'h0041, uart_tx_ready held low 4 cycles then high -> uart_tx_valid high 5 cycles, stall high 6 cycles, single transfer only.
- UART reads:
  - status with rx_valid=1, tx_ready=0 -> memDataOut=16'h0002.
  - data with rx_valid=0 -> 16'h0000, ack=0.
  - data with rx_valid=1, rx_data=8'h7E -> 16'h007E, one-cycle ack.
- Reset asserted in 2nd RAM_WR cycle -> ram_we_n/ram_en_n=1 and stall=0 immediately; state IDLE; no MEM/WB update after release.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: decodes the EX/MEM memory fields, runs multi-cycle SRAM
// and handshake-UART accesses while stalling the pipeline, and drives the MEM/WB fields.
module mem_stage_ctrl #(
  parameter int          WAIT_CYCLES    = 2,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  memReadIn,
  input  logic [1:0]  memWriteIn,
  input  logic [15:0] ALUResultIn,
  input  logic [15:0] dataIn,
  input  logic        memtoRegIn,
  input  logic        regWriteIn,
  input  logic [1:0]  writeSpecRegIn,
  input  logic [2:0]  registerToWriteIdIn,
  output logic        stall,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_data_o,
  input  logic [15:0] ram_data_i,
  output logic        ram_data_oe,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [15:0] uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ack,
  output logic [15:0] ALUResultOut,
  output logic [15:0] memDataOut,
  output logic        memtoRegOut,
  output logic        regWriteOut,
  output logic [1:0]  writeSpecRegOut,
  output logic [2:0]  registerToWriteIdOut
);

  localparam int             CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RAM_RD, RAM_WR, UART_TX, DONE} state_e;

  // The UART target is chosen by the mem code alone; the address is informational.
  logic unused_uart_addr;
  assign unused_uart_addr = ^UART_DATA_ADDR;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   ram_addr_q, ram_addr_d, ram_data_o_q, ram_data_o_d;
  logic          ram_data_oe_q, ram_data_oe_d;
  logic          ram_en_n_q, ram_en_n_d, ram_oe_n_q, ram_oe_n_d, ram_we_n_q, ram_we_n_d;
  logic [15:0]   tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  // Completed-instruction latch, written to MEM/WB in DONE
  logic [15:0]   lat_alu_q, lat_alu_d, lat_mdata_q, lat_mdata_d;
  logic          lat_m2r_q, lat_m2r_d, lat_rw_q, lat_rw_d;
  logic [1:0]    lat_wsr_q, lat_wsr_d;
  logic [2:0]    lat_id_q, lat_id_d;
  // MEM/WB outputs
  logic [15:0]   out_alu_q, out_alu_d, out_mdata_q, out_mdata_d;
  logic          out_m2r_q, out_m2r_d, out_rw_q, out_rw_d;
  logic [1:0]    out_wsr_q, out_wsr_d;
  logic [2:0]    out_id_q, out_id_d;

  // Decode: a non-zero read code always wins over any write code
  logic rd_ram, rd_uart_d, rd_uart_s, wr_ram, wr_uart, idle, accept;
  assign idle      = (state_q == IDLE);
  assign rd_ram    = (memReadIn == 2'b01);
  assign rd_uart_d = (memReadIn == 2'b10);
  assign rd_uart_s = (memReadIn == 2'b11);
  assign wr_ram    = (memReadIn == 2'b00) && (memWriteIn == 2'b01);
  assign wr_uart   = (memReadIn == 2'b00) && (memWriteIn == 2'b10);
  assign accept    = idle && (rd_ram || wr_ram || wr_uart);

  assign stall       = accept || (state_q == RAM_RD) || (state_q == RAM_WR) || (state_q == UART_TX);
  assign uart_rx_ack = idle && rd_uart_d && uart_rx_valid;

  // Next-state and next-output computation for the access FSM
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ram_addr_d    = ram_addr_q;
    ram_data_o_d  = ram_data_o_q;
    ram_data_oe_d = ram_data_oe_q;
    ram_en_n_d    = ram_en_n_q;
    ram_oe_n_d    = ram_oe_n_q;
    ram_we_n_d    = ram_we_n_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    lat_alu_d     = lat_alu_q;
    lat_mdata_d   = lat_mdata_q;
    lat_m2r_d     = lat_m2r_q;
    lat_rw_d      = lat_rw_q;
    lat_wsr_d     = lat_wsr_q;
    lat_id_d      = lat_id_q;
    out_alu_d     = out_alu_q;
    out_mdata_d   = out_mdata_q;
    out_m2r_d     = out_m2r_q;
    out_rw_d      = out_rw_q;
    out_wsr_d     = out_wsr_q;
    out_id_d      = out_id_q;
    unique case (state_q)
      IDLE: begin
        out_alu_d   = ALUResultIn;
        out_m2r_d   = memtoRegIn;
        out_rw_d    = regWriteIn;
        out_wsr_d   = writeSpecRegIn;
        out_id_d    = registerToWriteIdIn;
        out_mdata_d = 16'h0000;
        if (rd_uart_d && uart_rx_valid) out_mdata_d = {8'h00, uart_rx_data};
        if (rd_uart_s) out_mdata_d = {14'b0, uart_rx_valid, uart_tx_ready};
        lat_alu_d   = ALUResultIn;
        lat_mdata_d = 16'h0000;
        lat_m2r_d   = memtoRegIn;
        lat_rw_d    = regWriteIn;
        lat_wsr_d   = writeSpecRegIn;
        lat_id_d    = registerToWriteIdIn;
        if (accept) begin
          // Bubble into MEM/WB while the access is in flight
          out_rw_d  = 1'b0;
          out_wsr_d = 2'b00;
          cnt_d     = '0;
          if (rd_ram) begin
            state_d    = RAM_RD;
            ram_addr_d = ALUResultIn;
            ram_en_n_d = 1'b0;
            ram_oe_n_d = 1'b0;
          end else if (wr_ram) begin
            state_d       = RAM_WR;
            ram_addr_d    = ALUResultIn;
            ram_data_o_d  = dataIn;
            ram_data_oe_d = 1'b1;
            ram_en_n_d    = 1'b0;
            ram_we_n_d    = 1'b0;
          end else begin
            state_d    = UART_TX;
            tx_data_d  = dataIn;
            tx_valid_d = 1'b1;
          end
        end
      end
      RAM_RD: begin
        if (cnt_q == CNT_LAST) begin
          lat_mdata_d = ram_data_i;
          ram_en_n_d  = 1'b1;
          ram_oe_n_d  = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RAM_WR: begin
        // Bus drive stays on through DONE for data hold after we_n rises
        if (cnt_q == CNT_LAST) begin
          ram_en_n_d = 1'b1;
          ram_we_n_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UART_TX: begin
        if (uart_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        out_alu_d     = lat_alu_q;
        out_mdata_d   = lat_mdata_q;
        out_m2r_d     = lat_m2r_q;
        out_rw_d      = lat_rw_q;
        out_wsr_d     = lat_wsr_q;
        out_id_d      = lat_id_q;
        ram_data_oe_d = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops the strobes mid-access
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ram_addr_q    <= '0;
      ram_data_o_q  <= '0;
      ram_data_oe_q <= 1'b0;
      ram_en_n_q    <= 1'b1;
      ram_oe_n_q    <= 1'b1;
      ram_we_n_q    <= 1'b1;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      lat_alu_q     <= '0;
      lat_mdata_q   <= '0;
      lat_m2r_q     <= 1'b0;
      lat_rw_q      <= 1'b0;
      lat_wsr_q     <= '0;
      lat_id_q      <= '0;
      out_alu_q     <= '0;
      out_mdata_q   <= '0;
      out_m2r_q     <= 1'b0;
      out_rw_q      <= 1'b0;
      out_wsr_q     <= '0;
      out_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_o_q  <= ram_data_o_d;
      ram_data_oe_q <= ram_data_oe_d;
      ram_en_n_q    <= ram_en_n_d;
      ram_oe_n_q    <= ram_oe_n_d;
      ram_we_n_q    <= ram_we_n_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      lat_alu_q     <= lat_alu_d;
      lat_mdata_q   <= lat_mdata_d;
      lat_m2r_q     <= lat_m2r_d;
      lat_rw_q      <= lat_rw_d;
      lat_wsr_q     <= lat_wsr_d;
      lat_id_q      <= lat_id_d;
      out_alu_q     <= out_alu_d;
      out_mdata_q   <= out_mdata_d;
      out_m2r_q     <= out_m2r_d;
      out_rw_q      <= out_rw_d;
      out_wsr_q     <= out_wsr_d;
      out_id_q      <= out_id_d;
    end
  end

  assign ram_addr             = ram_addr_q;
  assign ram_data_o           = ram_data_o_q;
  assign ram_data_oe          = ram_data_oe_q;
  assign ram_en_n             = ram_en_n_q;
  assign ram_oe_n             = ram_oe_n_q;
  assign ram_we_n             = ram_we_n_q;
  assign uart_tx_data         = tx_data_q;
  assign uart_tx_valid        = tx_valid_q;
  assign ALUResultOut         = out_alu_q;
  assign memDataOut           = out_mdata_q;
  assign memtoRegOut          = out_m2r_q;
  assign regWriteOut          = out_rw_q;
  assign writeSpecRegOut      = out_wsr_q;
  assign registerToWriteIdOut = out_id_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (WAIT_CYCLES = 2).
module tb_mem_stage_ctrl;
  logic        CLK, RST;
  logic [1:0]  memReadIn, memWriteIn, writeSpecRegIn;
  logic [15:0] ALUResultIn, dataIn, ram_data_i;
  logic        memtoRegIn, regWriteIn;
  logic [2:0]  registerToWriteIdIn;
  logic        stall, ram_data_oe, ram_en_n, ram_oe_n, ram_we_n;
  logic [15:0] ram_addr, ram_data_o, uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ack;
  logic [7:0]  uart_rx_data;
  logic [15:0] ALUResultOut, memDataOut;
  logic        memtoRegOut, regWriteOut;
  logic [1:0]  writeSpecRegOut;
  logic [2:0]  registerToWriteIdOut;

  int tests = 0;
  int fails = 0;

  mem_stage_ctrl #(.WAIT_CYCLES(2), .UART_DATA_ADDR(16'hBF00)) dut (
    .CLK(CLK), .RST(RST),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .ALUResultIn(ALUResultIn), .dataIn(dataIn),
    .memtoRegIn(memtoRegIn), .regWriteIn(regWriteIn),
    .writeSpecRegIn(writeSpecRegIn), .registerToWriteIdIn(registerToWriteIdIn),
    .stall(stall), .ram_addr(ram_addr), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .ram_data_oe(ram_data_oe), .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ack(uart_rx_ack),
    .ALUResultOut(ALUResultOut), .memDataOut(memDataOut),
    .memtoRegOut(memtoRegOut), .regWriteOut(regWriteOut),
    .writeSpecRegOut(writeSpecRegOut), .registerToWriteIdOut(registerToWriteIdOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    memReadIn = 2'b00; memWriteIn = 2'b00; ALUResultIn = '0; dataIn = '0;
    memtoRegIn = 1'b0; regWriteIn = 1'b0; writeSpecRegIn = 2'b00; registerToWriteIdIn = '0;
  endtask

  initial begin
    int cyc, n_stall, n_valid, n_xfer;
    RST = 1'b0;
    clr_in();
    ram_data_i = '0; uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = '0;

    // Reset state
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_en_n", ram_en_n, 1);
    chk("rst_oe_n", ram_oe_n, 1);
    chk("rst_we_n", ram_we_n, 1);
    chk("rst_alu", ALUResultOut, 0);
    chk("rst_txv", uart_tx_valid, 0);
    RST = 1'b1;
    tick();

    // Plain ALU op passes straight through
    regWriteIn = 1'b1; ALUResultIn = 16'h00A5; registerToWriteIdIn = 3'd3;
    #1 chk("alu_stall", stall, 0);
    tick();
    chk("alu_out", ALUResultOut, 16'h00A5);
    chk("alu_rw", regWriteOut, 1);
    chk("alu_id", registerToWriteIdOut, 3);
    chk("alu_mdata", memDataOut, 0);
    chk("alu_stall2", stall, 0);

    // RAM read @1234 -> BEEF
    memReadIn = 2'b01; ALUResultIn = 16'h1234; memtoRegIn = 1'b1; regWriteIn = 1'b1;
    registerToWriteIdIn = 3'd5; ram_data_i = 16'hBEEF;
    #1 chk("rd_stall_acc", stall, 1);
    tick();
    chk("rd_stall_c0", stall, 1);
    chk("rd_oe_c0", ram_oe_n, 0);
    chk("rd_en_c0", ram_en_n, 0);
    chk("rd_addr", ram_addr, 16'h1234);
    chk("rd_bubble", regWriteOut, 0);
    tick();
    chk("rd_stall_c1", stall, 1);
    chk("rd_oe_c1", ram_oe_n, 0);
    tick();
    chk("rd_stall_done", stall, 0);
    chk("rd_oe_done", ram_oe_n, 1);
    chk("rd_bubble_done", regWriteOut, 0);
    clr_in(); ram_data_i = 16'h0000;
    tick();
    chk("rd_mdata", memDataOut, 16'hBEEF);
    chk("rd_m2r", memtoRegOut, 1);
    chk("rd_rw", regWriteOut, 1);
    chk("rd_id", registerToWriteIdOut, 5);
    chk("rd_alu", ALUResultOut, 16'h1234);

    // RAM write 5A5A @0040
    memWriteIn = 2'b01; ALUResultIn = 16'h0040; dataIn = 16'h5A5A;
    #1 chk("wr_stall_acc", stall, 1);
    chk("wr_doe_acc", ram_data_oe, 0);
    tick();
    chk("wr_we_c0", ram_we_n, 0);
    chk("wr_en_c0", ram_en_n, 0);
    chk("wr_oen_c0", ram_oe_n, 1);
    chk("wr_doe_c0", ram_data_oe, 1);
    chk("wr_data", ram_data_o, 16'h5A5A);
    chk("wr_addr", ram_addr, 16'h0040);
    chk("wr_stall_c0", stall, 1);
    tick();
    chk("wr_we_c1", ram_we_n, 0);
    chk("wr_stall_c1", stall, 1);
    tick();
    chk("wr_we_done", ram_we_n, 1);
    chk("wr_doe_done", ram_data_oe, 1);
    chk("wr_stall_done", stall, 0);
    clr_in();
    tick();
    chk("wr_doe_idle", ram_data_oe, 0);
    chk("wr_mdata", memDataOut, 0);

    // UART TX, ready held low for 4 cycles of the transfer
    memWriteIn = 2'b10; dataIn = 16'h0041; uart_tx_ready = 1'b0;
    #1;
    n_stall = stall ? 1 : 0; n_valid = 0; n_xfer = 0; cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (cyc == 1) chk("tx_data", uart_tx_data, 16'h0041);
      uart_tx_ready = (cyc >= 5);
      if (uart_tx_valid) n_valid++;
      if (uart_tx_valid && uart_tx_ready) n_xfer++;
      if (stall) n_stall++;
      else break;
    end
    chk("tx_bound", (cyc < 20), 1);
    chk("tx_valid_cyc", n_valid, 5);
    chk("tx_stall_cyc", n_stall, 6);
    chk("tx_xfers", n_xfer, 1);
    clr_in(); uart_tx_ready = 1'b0;
    tick();
    chk("tx_valid_after", uart_tx_valid, 0);

    // UART status read
    memReadIn = 2'b11; uart_rx_valid = 1'b1; uart_tx_ready = 1'b0;
    #1 chk("st_stall", stall, 0);
    chk("st_ack", uart_rx_ack, 0);
    tick();
    chk("st_mdata", memDataOut, 16'h0002);

    // UART data read, nothing available
    memReadIn = 2'b10; uart_rx_valid = 1'b0; uart_rx_data = 8'h55;
    #1 chk("rx0_ack", uart_rx_ack, 0);
    tick();
    chk("rx0_mdata", memDataOut, 16'h0000);

    // UART data read, byte available
    uart_rx_valid = 1'b1; uart_rx_data = 8'h7E;
    #1 chk("rx1_ack", uart_rx_ack, 1);
    chk("rx1_stall", stall, 0);
    tick();
    chk("rx1_mdata", memDataOut, 16'h007E);
    memReadIn = 2'b00; uart_rx_valid = 1'b0;
    #1 chk("rx1_ack_off", uart_rx_ack, 0);
    tick();

    // Read and write together: read wins
    memReadIn = 2'b01; memWriteIn = 2'b01; ALUResultIn = 16'h0100; ram_data_i = 16'h1111;
    tick();
    chk("rw_oe", ram_oe_n, 0);
    chk("rw_we", ram_we_n, 1);
    chk("rw_doe", ram_data_oe, 0);
    tick();
    tick();
    clr_in();
    tick();
    chk("rw_mdata", memDataOut, 16'h1111);
    tick();

    // Reset in the 2nd RAM_WR cycle
    memWriteIn = 2'b01; ALUResultIn = 16'h0040; dataIn = 16'h5A5A; regWriteIn = 1'b1;
    registerToWriteIdIn = 3'd6;
    tick();
    tick();
    chk("rs_we_before", ram_we_n, 0);
    #2 RST = 1'b0;
    clr_in();
    #1;
    chk("rs_we", ram_we_n, 1);
    chk("rs_en", ram_en_n, 1);
    chk("rs_stall", stall, 0);
    chk("rs_doe", ram_data_oe, 0);
    #1 RST = 1'b1;
    tick();
    tick();
    tick();
    chk("rs_alu", ALUResultOut, 0);
    chk("rs_rw", regWriteOut, 0);
    chk("rs_id", registerToWriteIdOut, 0);
    chk("rs_stall_after", stall, 0);
    chk("rs_we_after", ram_we_n, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
